mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
- Instruction fetch front-end that feeds the IF/ID register of the 5-stage MIPS32 pipeline.
- Issues word-addressed requests to an instruction memory with variable latency and in-order responses.
- Buffers returned instructions with their NPC in a prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports branch redirect with in-flight discard, and a sticky halt.

Parameters:
- DEPTH, 4, prefetch FIFO entries; also the cap on FIFO occupancy plus outstanding requests (power of 2, ≥2).
- RESET_PC, 32'h00000000, word address fetched first after reset.

Ports:
- clk1  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request; equals pc.
- imem_ack  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response word valid; responses return in request order.
- imem_rdata  in  32  response instruction word.
- redirect_valid  in  1  taken branch; flush and refetch.
- redirect_pc  in  32  branch target word address.
- halt  in  1  HLT retired; stop issuing requests.
- if_valid  out  1  FIFO head valid.
- if_ready  in  1  decode consumes the head.
- if_ir  out  32  head instruction.
- if_npc  out  32  head instruction address + 1.
- halted  out  1  sticky halt status.
- outstanding  out  $clog2(DEPTH)+1  requests accepted and not yet returned.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0; state RUN.
  - All outputs 0: imem_req, if_valid, halted, if_ir, if_npc, outstanding. imem_addr=RESET_PC.
- States:
  - RUN -> HALT when halt=1.
  - HALT is left only by reset.
  - In HALT, imem_req=0. Responses and FIFO draining continue normally, so buffered instructions still reach decode.
- Issue:
  - imem_req=1 iff state RUN, redirect_valid=0, halt=0, and occupancy+outstanding < DEPTH.
  - Handshake completes on imem_req & imem_ack. Then pc<=pc+1 (mod 2^32) and outstanding increments.
  - imem_addr stays stable while imem_req=1 and imem_ack=0.
- Response:
  - Every imem_rvalid decrements outstanding.
  - If drop_cnt>0, the word is discarded and drop_cnt decrements.
  - Otherwise push {imem_rdata, resp_pc+1}, then resp_pc<=resp_pc+1.
  - Credit rule guarantees no FIFO overflow.
  - imem_rvalid with outstanding==0 is ignored and changes no state.
- Same-cycle events:
  - Issue and response in one cycle: outstanding is unchanged.
  - Push and pop in one cycle: occupancy is unchanged. Pop with push into an empty FIFO is impossible because if_valid requires a registered entry.
- Latency:
  - Response at edge t appears on if_valid at t+1 (one-cycle registered FIFO write).
  - Minimum request-to-decode latency is memory latency + 1.
- Decode handshake:
  - if_ir and if_npc are held stable while if_valid=1 and if_ready=0.
  - Pop on if_valid & if_ready.
- Redirect (cycle with redirect_valid=1):
  - if_valid=0 and imem_req=0 combinationally.
  - FIFO cleared at the edge.
  - pc<=redirect_pc; resp_pc<=redirect_pc.
  - drop_cnt <= outstanding − (imem_rvalid ? 1 : 0). Any response in the redirect cycle is itself discarded.
  - A second redirect before the drain completes recomputes drop_cnt the same way. No word from an old path ever reaches decode.
- Halt and redirect in the same cycle: both apply. pc is updated, state goes to HALT, and no further requests are issued.
- Wrap: pc, resp_pc and npc are 32-bit modulo; 32'hFFFFFFFF+1=0.
- Reset mid-operation:
  - Immediate return to reset values.
  - The memory side must also be reset; responses after reset are treated as unsolicited and ignored.

Test Plan:
1. Reset, imem_ack=1, rvalid 1 cycle after ack with rdata=addr^32'hA5A5A5A5, if_ready=1 -> decode gets ir 0xA5A5A5A5,0xA5A5A5A4,0xA5A5A5A7 with npc 1,2,3, no gaps after fill.
2. if_ready=0, ack=1, 1-cycle latency -> exactly 4 requests (addr 0..3), then imem_req=0. FIFO full, outstanding=0. One pop -> exactly one new request, addr 4.
3. Memory latency 3, two requests outstanding, redirect_pc=0x40 -> next 2 rvalid dropped. First delivered entry has npc=0x41; next imem_addr values are 0x40,0x41.
4. halt=1 with 3 entries buffered, if_ready=1 -> imem_req stays 0 and halted=1. The 3 entries drain in order, then if_valid=0 permanently.
5. redirect_pc=32'hFFFFFFFF -> request addr 0xFFFFFFFF then 0x00000000; npc values 0x00000000, 0x00000001.
6. rst_n pulsed low with 2 outstanding and FIFO half full -> outputs return to reset values asynchronously. First request after release is RESET_PC. A stray rvalid with outstanding=0 leaves the FIFO empty.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
// Instruction fetch front-end feeding the IF/ID register of a 5-stage MIPS32
// pipeline. Issues word-addressed requests to an in-order, variable-latency
// instruction memory, buffers responses with their NPC in a prefetch FIFO and
// hands them to decode over a valid/ready handshake. Supports branch redirect
// (in-flight responses are discarded) and a sticky halt.
//
// Ports:
//   clk1, rst_n            clock (rising edge), asynchronous active-low reset
//   imem_req/addr/ack      request channel; addr is the current fetch pc
//   imem_rvalid/rdata      in-order response channel
//   redirect_valid/pc      taken branch: flush and refetch from redirect_pc
//   halt                   stop issuing requests (sticky until reset)
//   if_valid/ready/ir/npc  decode handshake on the FIFO head
//   halted                 sticky halt status
//   outstanding            requests accepted and not yet returned
module mips_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_ir,
  output logic [31:0]      if_npc,
  output logic             halted,
  output logic [CNT_W-1:0] outstanding
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0]   CAP   = (CNT_W+1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;

  // FIFO payload storage; only pointers and counts carry reset state.
  logic [31:0]      ir_mem  [DEPTH];
  logic [31:0]      npc_mem [DEPTH];

  logic             issue, rsp, push, pop;
  logic [CNT_W:0]   credit_used;

  // Buffered entries plus in-flight requests never exceed DEPTH, so every
  // response is guaranteed a FIFO slot.
  assign credit_used = {1'b0, cnt_q} + {1'b0, out_q};

  // rst_n gates the request so it reads 0 while reset is held.
  assign imem_req  = rst_n && (state_q == ST_RUN) && !redirect_valid && !halt &&
                     (credit_used < CAP);
  assign imem_addr = pc_q;
  assign if_valid  = (cnt_q != '0) && !redirect_valid;
  assign if_ir     = if_valid ? ir_mem[rd_q]  : 32'h0;
  assign if_npc    = if_valid ? npc_mem[rd_q] : 32'h0;
  assign halted    = (state_q == ST_HALT);
  assign outstanding = out_q;

  assign issue = imem_req && imem_ack;
  // A response with nothing outstanding is unsolicited and ignored.
  assign rsp   = imem_rvalid && (out_q != '0);
  // Responses still belonging to a pre-redirect path are dropped, as is any
  // response landing in the redirect cycle itself.
  assign push  = rsp && (drop_q == '0) && !redirect_valid;
  assign pop   = if_valid && if_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q + CNT_W'(issue) - CNT_W'(rsp);
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;

    if (halt) state_d = ST_HALT;

    if (redirect_valid) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      drop_d    = out_q - CNT_W'(rsp);
      cnt_d     = '0;
      rd_d      = '0;
      wr_d      = '0;
    end else begin
      if (issue) pc_d = pc_q + 32'd1;
      if (rsp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd1;
        wr_d      = wr_q + PTR_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  // FIFO write: the entry becomes visible to decode one cycle after the
  // response edge.
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem[wr_q]  <= imem_rdata;
      npc_mem[wr_q] <= resp_pc_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [31:0] SALT     = 32'hA5A5_A5A5;

  logic             clk1 = 1'b0;
  logic             rst_n = 1'b0;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack = 1'b0;
  logic             imem_rvalid = 1'b0;
  logic [31:0]      imem_rdata = 32'h0;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc = 32'h0;
  logic             halt = 1'b0;
  logic             if_valid;
  logic             if_ready = 1'b0;
  logic [31:0]      if_ir;
  logic [31:0]      if_npc;
  logic             halted;
  logic [CNT_W-1:0] outstanding;

  mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .if_valid(if_valid), .if_ready(if_ready), .if_ir(if_ir), .if_npc(if_npc),
    .halted(halted), .outstanding(outstanding)
  );

  always #5 clk1 = ~clk1;

  // Memory model: in-flight requests in order; live=0 once a redirect has
  // made the request's path stale.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          live;
  } req_t;

  req_t        mq[$];
  logic [63:0] exp_q[$];     // {ir, npc} instructions decode should receive, in order
  logic [63:0] pop_log[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_pc;
  bit          m_halted;
  int          cyc;
  int          lat_lo = 1, lat_hi = 1;
  bit          data_rand = 0;
  int          n_cmp = 0, n_bad = 0;

  task automatic model_clear();
    mq.delete(); exp_q.delete(); pop_log.delete(); acc_log.delete();
    m_pc = RESET_PC; m_halted = 0; cyc = 0;
  endtask

  // One clock cycle: check the DUT against the model at the negedge, advance
  // the model with the handshakes seen there, then drive the memory response.
  task automatic tick();
    bit          exp_req, exp_valid, acc, rsp, pop;
    req_t        r;
    logic [31:0] d;
    @(negedge clk1);
    exp_req   = !m_halted && !halt && !redirect_valid && (exp_q.size() + mq.size() < DEPTH);
    exp_valid = !redirect_valid && (exp_q.size() != 0);
    n_cmp++; if (imem_req !== exp_req) begin n_bad++; $display("FAIL imem_req: got %0b want %0b at %0t", imem_req, exp_req, $time); end
    n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL imem_addr: got %h want %h at %0t", imem_addr, m_pc, $time); end
    n_cmp++; if (outstanding !== CNT_W'(mq.size())) begin n_bad++; $display("FAIL outstanding: got %0d want %0d at %0t", outstanding, mq.size(), $time); end
    n_cmp++; if (halted !== m_halted) begin n_bad++; $display("FAIL halted: got %0b want %0b at %0t", halted, m_halted, $time); end
    n_cmp++; if (if_valid !== exp_valid) begin n_bad++; $display("FAIL if_valid: got %0b want %0b at %0t", if_valid, exp_valid, $time); end
    if (if_valid && exp_q.size() != 0) begin
      n_cmp++; if ({if_ir, if_npc} !== exp_q[0]) begin n_bad++; $display("FAIL head: got ir=%h npc=%h want ir=%h npc=%h at %0t", if_ir, if_npc, exp_q[0][63:32], exp_q[0][31:0], $time); end
    end
    acc = imem_req && imem_ack;
    rsp = imem_rvalid && (mq.size() != 0);
    pop = if_valid && if_ready;
    if (pop) begin
      pop_log.push_back({if_ir, if_npc});
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (rsp) begin
      r = mq.pop_front();
      if (r.live && !redirect_valid) exp_q.push_back({r.data, r.addr + 32'd1});
    end
    if (acc) begin
      d = data_rand ? $urandom() : (imem_addr ^ SALT);
      mq.push_back('{addr: imem_addr, data: d, due: cyc + $urandom_range(lat_hi, lat_lo), live: 1'b1});
      acc_log.push_back(imem_addr);
      m_pc = m_pc + 32'd1;
    end
    if (redirect_valid) begin
      foreach (mq[i]) mq[i].live = 1'b0;
      exp_q.delete();
      m_pc = redirect_pc;
    end
    if (halt) m_halted = 1;
    @(posedge clk1); #1;
    cyc++;
    imem_rvalid = (mq.size() != 0) && (cyc >= mq[0].due);
    imem_rdata  = (mq.size() != 0) ? mq[0].data : $urandom();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_ack = 0; imem_rvalid = 0; redirect_valid = 0; halt = 0; if_ready = 0;
    lat_lo = 1; lat_hi = 1; data_rand = 0;
    model_clear();
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_imem_req: got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_imem_addr: got %h want %h", imem_addr, RESET_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %0b want 0", if_valid); end
    n_cmp++; if ({if_ir, if_npc} !== 64'h0) begin n_bad++; $display("FAIL rst_if_data: got %h/%h want 0/0", if_ir, if_npc); end
    n_cmp++; if (halted !== 1'b0 || outstanding !== '0) begin n_bad++; $display("FAIL rst_status: got halted=%0b out=%0d want 0/0", halted, outstanding); end
    apply_reset();
  endtask

  task automatic test_stream();
    int k;
    apply_reset();
    imem_ack = 1; if_ready = 1;
    k = 0;
    while (pop_log.size() == 0 && k < 20) begin tick(); k++; end
    n_cmp++; if (pop_log.size() == 0) begin n_bad++; $display("FAIL stream_first_pop: got none within 20 cycles, want one"); end
    repeat (8) tick();
    n_cmp++; if (pop_log.size() != 9) begin n_bad++; $display("FAIL stream_gapless: got %0d pops want 9", pop_log.size()); end
    if (pop_log.size() >= 3) begin
      n_cmp++; if (pop_log[0] !== {32'hA5A5A5A5, 32'd1}) begin n_bad++; $display("FAIL stream_0: got %h want a5a5a5a5_00000001", pop_log[0]); end
      n_cmp++; if (pop_log[1] !== {32'hA5A5A5A4, 32'd2}) begin n_bad++; $display("FAIL stream_1: got %h want a5a5a5a4_00000002", pop_log[1]); end
      n_cmp++; if (pop_log[2] !== {32'hA5A5A5A7, 32'd3}) begin n_bad++; $display("FAIL stream_2: got %h want a5a5a5a7_00000003", pop_log[2]); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    imem_ack = 1; if_ready = 0;
    repeat (10) tick();
    n_cmp++; if (acc_log.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d requests want 4", acc_log.size()); end
    for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
      n_cmp++; if (acc_log[i] !== 32'(i)) begin n_bad++; $display("FAIL bp_addr%0d: got %h want %h", i, acc_log[i], i); end
    end
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || outstanding !== '0) begin n_bad++; $display("FAIL bp_full: got req=%0b valid=%0b out=%0d want 0/1/0", imem_req, if_valid, outstanding); end
    if_ready = 1; tick(); if_ready = 0;
    repeat (6) tick();
    n_cmp++; if (acc_log.size() != 5) begin n_bad++; $display("FAIL bp_refill: got %0d requests want 5", acc_log.size()); end
    else begin
      n_cmp++; if (acc_log[4] !== 32'd4) begin n_bad++; $display("FAIL bp_refill_addr: got %h want 4", acc_log[4]); end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    lat_lo = 3; lat_hi = 3; imem_ack = 1; if_ready = 1;
    tick(); tick();
    imem_ack = 0;
    n_cmp++; if (outstanding !== CNT_W'(2)) begin n_bad++; $display("FAIL redir_pre_out: got %0d want 2", outstanding); end
    redirect_valid = 1; redirect_pc = 32'h40;
    acc_log.delete(); pop_log.delete();
    tick();
    redirect_valid = 0; imem_ack = 1;
    repeat (15) tick();
    n_cmp++; if (acc_log.size() < 2 || acc_log[0] !== 32'h40 || acc_log[1] !== 32'h41) begin n_bad++; $display("FAIL redir_addr: got %0d reqs first %h want 40,41", acc_log.size(), (acc_log.size() != 0) ? acc_log[0] : 32'hx); end
    n_cmp++; if (pop_log.size() == 0 || pop_log[0] !== {32'h40 ^ SALT, 32'h41}) begin n_bad++; $display("FAIL redir_first: got %h want %h", (pop_log.size() != 0) ? pop_log[0] : 64'hx, {32'h40 ^ SALT, 32'h41}); end
  endtask

  task automatic test_halt();
    apply_reset();
    imem_ack = 1; if_ready = 0;
    repeat (3) tick();
    imem_ack = 0;
    repeat (4) tick();
    n_cmp++; if (if_valid !== 1'b1 || outstanding !== '0) begin n_bad++; $display("FAIL halt_pre: got valid=%0b out=%0d want 1/0", if_valid, outstanding); end
    halt = 1; if_ready = 1;
    acc_log.delete(); pop_log.delete();
    tick();
    halt = 0; imem_ack = 1;
    repeat (8) tick();
    n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0 || acc_log.size() != 0) begin n_bad++; $display("FAIL halt_stop: got halted=%0b req=%0b reqs=%0d want 1/0/0", halted, imem_req, acc_log.size()); end
    n_cmp++; if (pop_log.size() != 3) begin n_bad++; $display("FAIL halt_drain: got %0d pops want 3", pop_log.size()); end
    for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
      n_cmp++; if (pop_log[i][31:0] !== 32'(i + 1)) begin n_bad++; $display("FAIL halt_npc%0d: got %h want %h", i, pop_log[i][31:0], i + 1); end
    end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL halt_empty: got if_valid=%0b want 0", if_valid); end
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_ack = 1; if_ready = 1;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 0;
    repeat (6) tick();
    n_cmp++; if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFF || acc_log[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %0d reqs first %h want ffffffff,0", acc_log.size(), (acc_log.size() != 0) ? acc_log[0] : 32'hx); end
    n_cmp++; if (pop_log.size() < 2 || pop_log[0][31:0] !== 32'h0 || pop_log[1][31:0] !== 32'h1) begin n_bad++; $display("FAIL wrap_npc: got %0d pops want npc 0,1", pop_log.size()); end
    n_cmp++; if (pop_log.size() == 0 || pop_log[0][63:32] !== (32'hFFFF_FFFF ^ SALT)) begin n_bad++; $display("FAIL wrap_ir: got %h want %h", (pop_log.size() != 0) ? pop_log[0][63:32] : 32'hx, 32'hFFFF_FFFF ^ SALT); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lat_lo = 3; lat_hi = 3; imem_ack = 1; if_ready = 0;
    repeat (5) tick();
    n_cmp++; if (outstanding !== CNT_W'(2) || exp_q.size() != 2) begin n_bad++; $display("FAIL rmid_pre: got out=%0d buffered=%0d want 2/2", outstanding, exp_q.size()); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || halted !== 1'b0 || outstanding !== '0 || imem_addr !== RESET_PC || if_ir !== 32'h0 || if_npc !== 32'h0) begin
      n_bad++; $display("FAIL rmid_async: got req=%0b valid=%0b halted=%0b out=%0d addr=%h ir=%h npc=%h want reset values", imem_req, if_valid, halted, outstanding, imem_addr, if_ir, if_npc);
    end
    imem_ack = 0; imem_rvalid = 0; lat_lo = 1; lat_hi = 1;
    model_clear();
    @(posedge clk1); #1;
    rst_n = 1'b1;
    imem_rvalid = 1'b1;  // unsolicited response
    tick();
    n_cmp++; if (if_valid !== 1'b0 || outstanding !== '0) begin n_bad++; $display("FAIL rmid_stray: got valid=%0b out=%0d want 0/0", if_valid, outstanding); end
    imem_ack = 1;
    tick();
    n_cmp++; if (acc_log.size() == 0 || acc_log[0] !== RESET_PC) begin n_bad++; $display("FAIL rmid_first_req: got %h want %h", (acc_log.size() != 0) ? acc_log[0] : 32'hx, RESET_PC); end
  endtask

  task automatic test_random();
    apply_reset();
    lat_lo = 1; lat_hi = 4; data_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      imem_ack = ($urandom_range(3, 0) != 0);
      if_ready = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom();
      halt = (i == 1400);
      tick();
    end
    redirect_valid = 0; halt = 0; if_ready = 1; imem_ack = 1;
    repeat (40) tick();
    n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || outstanding !== '0 || halted !== 1'b1) begin n_bad++; $display("FAIL rand_end: got valid=%0b req=%0b out=%0d halted=%0b want 0/0/0/1", if_valid, imem_req, outstanding, halted); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
